// File: rtl/rv64m_pkg.sv
// rv64m_pkg: shared encodings, FSM state type and iteration counts
// for the RV64M multiply/divide unit.
package rv64m_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MD_ITER_64 = 64;
    localparam int MD_ITER_32 = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: final negate, result select and word sign-extension
// applied to the unsigned magnitudes produced by the iteration datapath.
module muldiv_sign_fix
    import rv64m_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        funct3,
    input  logic              word,
    input  logic              neg_a,
    input  logic              neg_b,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   rem,
    output logic [XLEN-1:0]   result
);
    logic [2*XLEN-1:0] sprod;
    logic [XLEN-1:0]   squo, srem, sel;

    // Unsigned operands never set the neg flags, so one rule covers MULH/MULHSU/MULHU
    assign sprod  = (neg_a ^ neg_b) ? -prod : prod;
    assign squo   = (neg_a ^ neg_b) ? -quo : quo;
    assign srem   = neg_a ? -rem : rem;
    assign sel    = (funct3 == F3_MUL) ? sprod[XLEN-1:0] :
                    !funct3[2]         ? sprod[2*XLEN-1:XLEN] :
                    funct3[1]          ? srem : squo;
    assign result = word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit for the EX stage; stalls
// the pipeline while a shift-add multiply or restoring divide runs.
module ex_muldiv
    import rv64m_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            flush,
    input  logic            word,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);
    md_state_t         state, nxt;
    logic [5:0]        cnt;
    logic [2:0]        f3;
    logic              wd, neg_a, neg_b;
    logic [2*XLEN-1:0] acc, mul_n;
    logic [XLEN-1:0]   rem, ub, ext_a, ext_b, sx_a, mag_a, mag_b, short_res, fix_res;
    logic [XLEN:0]     sum, rem_sh;
    logic              sgn_a, sgn_b, in_neg_a, is_div, div0, ovf, illegal, short, ge, accept;

    assign sgn_a    = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    assign sgn_b    = funct3 inside {F3_MULH, F3_DIV, F3_REM};
    assign ext_a    = word ? {{(XLEN-32){sgn_a & op_a[31]}}, op_a[31:0]} : op_a;
    assign ext_b    = word ? {{(XLEN-32){sgn_b & op_b[31]}}, op_b[31:0]} : op_b;
    assign sx_a     = word ? {{(XLEN-32){op_a[31]}}, op_a[31:0]} : op_a;
    assign in_neg_a = sgn_a & ext_a[XLEN-1];
    assign mag_a    = in_neg_a ? -ext_a : ext_a;
    assign mag_b    = (sgn_b & ext_b[XLEN-1]) ? -ext_b : ext_b;
    assign is_div   = funct3[2];
    assign div0     = is_div & (ext_b == '0);
    assign ovf      = is_div & sgn_b & (ext_b == '1) &
                      (ext_a == (word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}}));
    assign illegal  = word & (funct3 inside {F3_MULH, F3_MULHSU, F3_MULHU});
    assign short    = illegal | div0 | ovf;
    assign short_res = illegal ? '0 :
                       div0    ? (funct3[1] ? sx_a : '1) :
                                 (funct3[1] ? '0 : sx_a);
    assign accept   = (state == S_IDLE) & start & ~flush;

    // Multiply step: conditional add into the high half, then shift right
    assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ub} : '0);
    assign mul_n  = {sum, acc[XLEN-1:1]};
    // Divide step: quotient lives in acc low half, dividend bits shift out of its top
    assign rem_sh = {rem, acc[XLEN-1]};
    assign ge     = rem_sh >= {1'b0, ub};

    muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
        .funct3 (f3),
        .word   (wd),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .prod   (wd ? acc >> 32 : acc),
        .quo    (acc[XLEN-1:0]),
        .rem    (rem),
        .result (fix_res)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = flush              ? S_IDLE :
              state == S_IDLE    ? (start ? (short ? S_DONE : S_CALC) : S_IDLE) :
              state == S_CALC    ? (cnt == '0 ? S_FIX : S_CALC) :
              state == S_FIX     ? S_DONE : S_IDLE;
    end

    always_comb begin
        busy      = state != S_IDLE;
        stall_req = ((state == S_IDLE) & start) | (state == S_CALC) | (state == S_FIX);
        done      = state == S_DONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            f3     <= '0;
            wd     <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            acc    <= '0;
            rem    <= '0;
            ub     <= '0;
            result <= '0;
        end else if (accept) begin
            f3     <= funct3;
            wd     <= word;
            neg_a  <= in_neg_a;
            neg_b  <= sgn_b & ext_b[XLEN-1];
            cnt    <= word ? 6'(MD_ITER_32 - 1) : 6'(MD_ITER_64 - 1);
            acc    <= {{XLEN{1'b0}}, (word & is_div) ? mag_a << 32 : mag_a};
            rem    <= '0;
            ub     <= mag_b;
            result <= short ? short_res : result;
        end else if (!flush && state == S_CALC) begin
            cnt    <= cnt - 6'd1;
            acc    <= f3[2] ? {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ge} : mul_n;
            rem    <= f3[2] ? (ge ? XLEN'(rem_sh - {1'b0, ub}) : rem_sh[XLEN-1:0]) : rem;
        end else if (!flush && state == S_FIX) begin
            result <= fix_res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector bench for ex_muldiv covering results,
// latency, stall behaviour, short-circuits and abort paths.
module tb_ex_muldiv;
    logic        clk, rstn, start, flush, word, busy, stall_req, done;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b, result;
    int          total = 0, bad = 0;

    ex_muldiv dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .flush     (flush),
        .word      (word),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op from posedge+1, returns in the IDLE cycle after done.
    // lat counts edges from the accepting edge to the first done cycle.
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output int stl, output logic st0);
        funct3 = f; word = w; op_a = a; op_b = b; start = 1'b1;
        #1 st0 = stall_req;
        @(posedge clk); #1 start = 1'b0;
        lat = 1; stl = 0;
        while (!done && lat < 200) begin
            if (stall_req) stl++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; flush = 1'b0; word = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        #3;
        total++;
        if ({busy, stall_req, done, result} !== 67'd0) begin
            bad++; $display("FAIL reset_outputs got busy=%b stall=%b done=%b result=%h want all 0", busy, stall_req, done, result);
        end
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, stall_req, done, result} !== 67'd0) begin
            bad++; $display("FAIL idle_after_reset got busy=%b stall=%b done=%b result=%h want all 0", busy, stall_req, done, result);
        end
    endtask

    task automatic test_mul;
        logic [2:0]  fv [4] = '{3'b000, 3'b011, 3'b010, 3'b001};
        logic [63:0] av [4] = '{64'd7, '1, '1, 64'h4000_0000_0000_0000};
        logic [63:0] bv [4] = '{-64'sd3, '1, 64'd2, 64'd8};
        logic [63:0] ev [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, '1, 64'd2};
        logic [63:0] res; int lat, stl; logic st0;
        for (int i = 0; i < 4; i++) begin
            run_op(fv[i], 1'b0, av[i], bv[i], res, lat, stl, st0);
            total++;
            if (res !== ev[i]) begin bad++; $display("FAIL mul_result[%0d] got %h want %h", i, res, ev[i]); end
            total++;
            if (lat !== 66) begin bad++; $display("FAIL mul_latency[%0d] got %0d want 66", i, lat); end
            if (i == 0) begin
                total++;
                if (st0 !== 1'b1 || stl !== 65) begin
                    bad++; $display("FAIL mul_stall got start_cycle=%b later=%0d want 1 and 65", st0, stl);
                end
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  fv [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [63:0] av [4] = '{-64'sd7, -64'sd7, 64'd100, 64'd100};
        logic [63:0] bv [4] = '{64'd2, 64'd2, 64'd7, 64'd7};
        logic [63:0] ev [4] = '{-64'sd3, '1, 64'd14, 64'd2};
        logic [63:0] res; int lat, stl; logic st0;
        for (int i = 0; i < 4; i++) begin
            run_op(fv[i], 1'b0, av[i], bv[i], res, lat, stl, st0);
            total++;
            if (res !== ev[i] || lat !== 66) begin
                bad++; $display("FAIL div[%0d] got %h lat=%0d want %h lat=66", i, res, lat, ev[i]);
            end
        end
    endtask

    task automatic test_short;
        logic [2:0]  fv [4] = '{3'b100, 3'b110, 3'b100, 3'b001};
        logic        wv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] av [4] = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'd9};
        logic [63:0] bv [4] = '{64'd0, 64'd0, '1, 64'd9};
        logic [63:0] ev [4] = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
        logic [63:0] res; int lat, stl; logic st0;
        for (int i = 0; i < 4; i++) begin
            run_op(fv[i], wv[i], av[i], bv[i], res, lat, stl, st0);
            total++;
            if (res !== ev[i]) begin bad++; $display("FAIL short_result[%0d] got %h want %h", i, res, ev[i]); end
            total++;
            if (lat !== 1 || stl !== 0 || st0 !== 1'b1) begin
                bad++; $display("FAIL short_timing[%0d] got lat=%0d stl=%0d st0=%b want 1 0 1", i, lat, stl, st0);
            end
        end
    endtask

    task automatic test_word;
        logic [2:0]  fv [3] = '{3'b100, 3'b000, 3'b111};
        logic [63:0] av [3] = '{64'h1_8000_0000, 64'h7FFF_FFFF, 64'hDEAD_0000_FFFF_FFF9};
        logic [63:0] bv [3] = '{64'd1, 64'd2, 64'd4};
        logic [63:0] ev [3] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
        logic [63:0] res; int lat, stl; logic st0;
        for (int i = 0; i < 3; i++) begin
            run_op(fv[i], 1'b1, av[i], bv[i], res, lat, stl, st0);
            total++;
            if (res !== ev[i] || lat !== 34) begin
                bad++; $display("FAIL word[%0d] got %h lat=%0d want %h lat=34", i, res, lat, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] res; int lat, stl; logic st0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width got done=%b busy=%b want 0 0", done, busy);
        end
        run_op(3'b101, 1'b0, 64'd1000, 64'd10, res, lat, stl, st0);
        total++;
        if (res !== 64'd100) begin bad++; $display("FAIL b2b_first got %h want %h", res, 64'd100); end
        run_op(3'b000, 1'b0, 64'd12, 64'd12, res, lat, stl, st0);
        total++;
        if (res !== 64'd144 || lat !== 66) begin
            bad++; $display("FAIL b2b_second got %h lat=%0d want %h lat=66", res, lat, 64'd144);
        end
    endtask

    task automatic test_flush;
        int dones = 0;
        funct3 = 3'b100; word = 1'b0; op_a = 64'd1234; op_b = 64'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd144) begin
            bad++; $display("FAIL flush_abort got busy=%b done=%b result=%h want 0 0 %h", busy, done, result, 64'd144);
        end
        repeat (70) begin @(posedge clk); #1; if (done) dones++; end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL flush_no_done got %0d done cycles want 0", dones); end
        flush = 1'b1; start = 1'b1; funct3 = 3'b100; op_b = 64'd0;
        @(posedge clk); #1 flush = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || result !== 64'd144) begin
            bad++; $display("FAIL flush_beats_start got busy=%b result=%h want 0 %h", busy, result, 64'd144);
        end
    endtask

    task automatic test_start_ignored;
        int lat = 1;
        funct3 = 3'b101; word = 1'b0; op_a = 64'd100; op_b = 64'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done && lat < 200) begin
            start = (lat == 5);
            if (lat == 5) begin funct3 = 3'b000; op_a = 64'd3; op_b = 64'd3; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        total++;
        if (result !== 64'd14 || lat !== 66) begin
            bad++; $display("FAIL start_in_calc got %h lat=%0d want %h lat=66", result, lat, 64'd14);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        funct3 = 3'b000; word = 1'b0; op_a = 64'd5; op_b = 64'd6; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        total++;
        if ({busy, stall_req, done, result} !== 67'd0) begin
            bad++; $display("FAIL reset_mid got busy=%b stall=%b done=%b result=%h want all 0", busy, stall_req, done, result);
        end
        #3 rstn = 1'b1;
        repeat (80) begin @(posedge clk); #1; if (done) dones++; end
        total++;
        if (dones !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_quiet got dones=%0d busy=%b want 0 0", dones, busy);
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_short;
        test_word;
        test_back_to_back;
        test_flush;
        test_start_ignored;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
